csi_tx_packet_gen: RTL and testbench

CSI-2 transmit-side packetizer: the transmitting peer of the CSI-2 receive path (byte aligner, word combiner, packet handler) used for loopback tests and camera emulation. Accepts packet commands (VC, DT, WC) plus a payload stream. Emits per-lane HS byte streams: SoT sync byte, packet header with ECC, payload, CRC-16 footer, HS trailer, then an LP gap. Sits in the byte-clock domain upstream of the lane serializers.

---
 rtl/csi_tx_packet_gen.sv | 192 +++++++++++++++++++
 tb/tb_csi_tx_packet_gen.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/csi_tx_packet_gen.sv
// CSI-2 transmit packetizer: SoT, header + ECC, payload,
// CRC-16 footer and HS trailer per lane, then an LP gap.
module csi_tx_packet_gen #(
   parameter int LANES        = 2,
   parameter int TRAIL_CYCLES = 4,
   parameter int GAP_CYCLES   = 16
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               cmd_valid,
   output logic               cmd_ready,
   input  logic [1:0]         cmd_vc,
   input  logic [5:0]         cmd_dt,
   input  logic [15:0]        cmd_wc,
   input  logic [8*LANES-1:0] pay_data,
   input  logic               pay_valid,
   output logic               pay_ready,
   output logic               hs_active,
   output logic [8*LANES-1:0] lane_bytes,
   output logic               pkt_done,
   output logic               err_underflow,
   output logic               err_wc
);
   localparam int W = 8 * LANES;

   // Syndrome column for each header data bit, D23 first
   localparam logic [23:0][5:0] ECC_COL = {
      6'h3B, 6'h37, 6'h2F, 6'h1F, 6'h38, 6'h34,
      6'h32, 6'h31, 6'h2C, 6'h2A, 6'h29, 6'h26,
      6'h25, 6'h23, 6'h1C, 6'h1A, 6'h19, 6'h16,
      6'h15, 6'h13, 6'h0E, 6'h0D, 6'h0B, 6'h07};

   typedef enum logic [2:0] {
      S_IDLE, S_SOT, S_HDR, S_PAY, S_CRC, S_TRAIL, S_GAP
   } state_t;

   state_t       state, state_d;
   logic [1:0]   vc_q;
   logic [5:0]   dt_q;
   logic [15:0]  wc_q;
   logic [15:0]  cnt, lim, pay_len;
   logic [15:0]  crc, crc_d;
   logic [31:0]  hdr;
   logic [W-1:0] lane_d;
   logic         hs_d, done_d, unf_d, ewc_d;
   logic         acc, bad, last, is_long;

   function automatic logic [5:0] ecc(input logic [23:0] d);
      logic [5:0] p;
      p = '0;
      for (int i = 0; i < 24; i++)
         if (d[i]) p = p ^ ECC_COL[i];
      return p;
   endfunction

   function automatic logic [15:0] crc_byte(input logic [15:0] c,
                                            input logic [7:0] b);
      logic [15:0] r;
      r = c;
      for (int i = 0; i < 8; i++)
         r = (r[0] ^ b[i]) ? ((r >> 1) ^ 16'h8408) : (r >> 1);
      return r;
   endfunction

   assign cmd_ready = (state == S_IDLE) && !reset;
   assign pay_ready = (state == S_PAY) && !reset;
   assign acc       = cmd_valid && cmd_ready;
   // Odd byte counts cannot be split evenly over two lanes
   assign bad       = (LANES == 2) && (cmd_dt >= 6'h10) && cmd_wc[0];
   assign is_long   = dt_q >= 6'h10;
   assign pay_len   = wc_q >> (LANES - 1);
   assign last      = cnt == lim;
   assign hdr       = {2'b00, ecc({wc_q, vc_q, dt_q}), wc_q, vc_q, dt_q};

   // State register, per-state cycle counter and latched command
   always_ff @(posedge clock) begin
      if (reset) begin
         state <= S_IDLE;
         cnt   <= '0;
         vc_q  <= '0;
         dt_q  <= '0;
         wc_q  <= '0;
      end else begin
         state <= state_d;
         cnt   <= (state_d != state) ? 16'd0 : cnt + 16'd1;
         if (acc) begin
            vc_q <= cmd_vc;
            dt_q <= cmd_dt;
            wc_q <= cmd_wc;
         end
      end
   end

   // Next state; GAP holds one extra cycle while the last trailer drains
   always_comb begin
      state_d = state;
      lim     = '0;
      unique case (state)
         S_IDLE:  if (acc && !bad) state_d = S_SOT;
         S_SOT:   state_d = S_HDR;
         S_HDR: begin
            lim = 16'(4 / LANES - 1);
            if (last)
               state_d = !is_long ? S_TRAIL :
                         (pay_len == 16'd0) ? S_CRC : S_PAY;
         end
         S_PAY: begin
            lim = pay_len - 16'd1;
            if (last) state_d = S_CRC;
         end
         S_CRC: begin
            lim = 16'(2 / LANES - 1);
            if (last) state_d = S_TRAIL;
         end
         S_TRAIL: begin
            lim = 16'(TRAIL_CYCLES - 1);
            if (last) state_d = S_GAP;
         end
         S_GAP: begin
            lim = 16'(GAP_CYCLES);
            if (last) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Lane bytes and flags for the next output cycle, plus CRC update
   always_comb begin
      lane_d = '0;
      hs_d   = 1'b0;
      done_d = 1'b0;
      unf_d  = 1'b0;
      ewc_d  = acc && bad;
      crc_d  = crc;
      unique case (state)
         S_SOT: begin
            hs_d   = 1'b1;
            lane_d = {LANES{8'hB8}};
            crc_d  = 16'hFFFF;
         end
         S_HDR: begin
            hs_d = 1'b1;
            for (int l = 0; l < LANES; l++)
               lane_d[8*l +: 8] =
                  hdr[8*(int'(cnt[1:0])*LANES + l) +: 8];
         end
         S_PAY: begin
            hs_d = 1'b1;
            if (pay_valid) lane_d = pay_data;
            else           unf_d  = 1'b1;
            for (int l = 0; l < LANES; l++)
               crc_d = crc_byte(crc_d, lane_d[8*l +: 8]);
         end
         S_CRC: begin
            hs_d = 1'b1;
            for (int l = 0; l < LANES; l++)
               lane_d[8*l +: 8] =
                  crc[8*(int'(cnt[0])*LANES + l) +: 8];
         end
         S_TRAIL: begin
            hs_d   = 1'b1;
            done_d = last;
            if (cnt == 16'd0) begin
               for (int l = 0; l < LANES; l++)
                  lane_d[8*l +: 8] = {8{~lane_bytes[8*l+7]}};
            end else begin
               lane_d = lane_bytes;
            end
         end
         default: ;
      endcase
   end

   // Registered lane outputs and status pulses
   always_ff @(posedge clock) begin
      if (reset) begin
         lane_bytes    <= '0;
         hs_active     <= 1'b0;
         pkt_done      <= 1'b0;
         err_underflow <= 1'b0;
         err_wc        <= 1'b0;
         crc           <= 16'hFFFF;
      end else begin
         lane_bytes    <= lane_d;
         hs_active     <= hs_d;
         pkt_done      <= done_d;
         err_underflow <= unf_d;
         err_wc        <= ewc_d;
         crc           <= crc_d;
      end
   end
endmodule

// File: tb/tb_csi_tx_packet_gen.sv
// Directed bench for csi_tx_packet_gen (LANES=2): captures the
// HS lane stream per packet and compares with hand-built vectors.
module tb_csi_tx_packet_gen;
   logic        clock = 1'b0;
   logic        reset;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [1:0]  cmd_vc;
   logic [5:0]  cmd_dt;
   logic [15:0] cmd_wc;
   logic [15:0] pay_data;
   logic        pay_valid;
   logic        pay_ready;
   logic        hs_active;
   logic [15:0] lane_bytes;
   logic        pkt_done;
   logic        err_underflow;
   logic        err_wc;

   csi_tx_packet_gen #(
      .LANES(2), .TRAIL_CYCLES(4), .GAP_CYCLES(16)
   ) dut (
      .clock(clock), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_vc(cmd_vc), .cmd_dt(cmd_dt), .cmd_wc(cmd_wc),
      .pay_data(pay_data), .pay_valid(pay_valid),
      .pay_ready(pay_ready), .hs_active(hs_active),
      .lane_bytes(lane_bytes), .pkt_done(pkt_done),
      .err_underflow(err_underflow), .err_wc(err_wc)
   );

   always #5 clock = ~clock;

   int n_cmp = 0;
   int n_bad = 0;

   logic [15:0] words [4];
   logic [15:0] obs [$];
   logic [15:0] expq [$];
   logic [15:0] ecrc;
   int done_idx, n_unf, n_errwc, n_pay, gap_low, hs_seen;
   int gap_ok;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] crc_upd(input logic [15:0] c,
                                           input logic [7:0] b);
      logic [7:0] x;
      x = b ^ c[7:0];
      x = x ^ {x[3:0], 4'h0};
      return {x, c[15:8]} ^ {12'h000, x[7:4]} ^ {5'b0, x, 3'b000};
   endfunction

   task automatic exp_pay(input logic [15:0] w);
      expq.push_back(w);
      ecrc = crc_upd(ecrc, w[7:0]);
      ecrc = crc_upd(ecrc, w[15:8]);
   endtask

   task automatic exp_trail(input logic [15:0] lst);
      logic [15:0] t;
      t = {lst[15] ? 8'h00 : 8'hFF, lst[7] ? 8'h00 : 8'hFF};
      repeat (4) expq.push_back(t);
   endtask

   task automatic wait_ready(input string tag);
      int t;
      t = 0;
      while (!cmd_ready && t < 60) begin
         @(negedge clock);
         t++;
      end
      chk($sformatf("%s.rdy", tag), 32'(cmd_ready), 32'd1);
   endtask

   task automatic run_pkt(input string tag, input logic [1:0] vc,
                          input logic [5:0] dt, input logic [15:0] wc,
                          input int stall_at, input bit expect_pkt);
      int widx, pcyc, done, c;
      obs.delete();
      done_idx = -1; n_unf = 0; n_errwc = 0; n_pay = 0;
      gap_low = 0; gap_ok = 0; hs_seen = 0;
      widx = 0; pcyc = 0; done = 0; c = 0;
      wait_ready(tag);
      cmd_vc = vc; cmd_dt = dt; cmd_wc = wc; cmd_valid = 1'b1;
      while (!done && c < 300) begin
         @(negedge clock);
         c++;
         cmd_valid = 1'b0;
         if (hs_active) begin
            obs.push_back(lane_bytes);
            hs_seen++;
         end
         if (pkt_done) begin
            done_idx = obs.size();
            done = 1;
         end
         if (err_underflow) n_unf++;
         if (err_wc) n_errwc++;
         if (pay_ready) begin
            pcyc++;
            n_pay++;
            pay_valid = (pcyc != stall_at);
            pay_data  = (widx < 4) ? words[widx] : 16'hDEAD;
            if (pay_valid) widx++;
         end else begin
            pay_valid = 1'b0;
         end
         if (!expect_pkt && c >= 20) done = 1;
      end
      pay_valid = 1'b0;
      if (expect_pkt) begin
         chk($sformatf("%s.finished", tag), 32'(done), 32'd1);
         c = 0;
         while (!gap_ok && c < 100) begin
            @(negedge clock);
            c++;
            if (cmd_ready) gap_ok = 1;
            else if (!hs_active) gap_low++;
         end
      end
   endtask

   task automatic compare(input string tag);
      chk($sformatf("%s.len", tag), obs.size(), expq.size());
      for (int i = 0; i < expq.size(); i++)
         chk($sformatf("%s.w%0d", tag, i),
             (i < obs.size()) ? {16'h0, obs[i]} : 32'hFFFF_FFFF,
             {16'h0, expq[i]});
      chk($sformatf("%s.done_at", tag), done_idx, expq.size());
   endtask

   task automatic exp_short_1234();
      expq.delete();
      expq.push_back(16'hB8B8);
      expq.push_back(16'h3441);
      expq.push_back(16'h1012);
      exp_trail(16'h1012);
   endtask

   initial begin
      reset = 1'b1; cmd_valid = 1'b0; cmd_vc = '0; cmd_dt = '0;
      cmd_wc = '0; pay_data = '0; pay_valid = 1'b0;
      words[0] = 16'hA501; words[1] = 16'h3C7E;
      words[2] = 16'h8002; words[3] = 16'hF00F;
      repeat (3) @(negedge clock);
      chk("rst.cmd_ready", 32'(cmd_ready), 32'd0);
      chk("rst.hs_active", 32'(hs_active), 32'd0);
      chk("rst.lanes", 32'(lane_bytes), 32'd0);
      chk("rst.pay_ready", 32'(pay_ready), 32'd0);
      reset = 1'b0;
      @(negedge clock);
      chk("idle.cmd_ready", 32'(cmd_ready), 32'd1);

      // short packet, all-zero header
      expq.delete();
      expq.push_back(16'hB8B8);
      expq.push_back(16'h0000);
      expq.push_back(16'h0000);
      exp_trail(16'h0000);
      run_pkt("short0", 2'd0, 6'h00, 16'd0, 0, 1);
      compare("short0");
      chk("short0.gap_low", gap_low, 32'd16);
      chk("short0.gap_ready", gap_ok, 32'd1);
      chk("short0.pay_cycles", n_pay, 32'd0);

      // long packet, empty payload: CRC = init value
      expq.delete();
      expq.push_back(16'hB8B8);
      expq.push_back(16'h002A);
      expq.push_back(16'h1000);
      expq.push_back(16'hFFFF);
      exp_trail(16'hFFFF);
      run_pkt("long0", 2'd0, 6'h2A, 16'd0, 0, 1);
      compare("long0");
      chk("long0.pay_cycles", n_pay, 32'd0);

      // long packet, 8 bytes, always valid
      expq.delete();
      expq.push_back(16'hB8B8);
      expq.push_back(16'h082A);
      expq.push_back(16'h3500);
      ecrc = 16'hFFFF;
      for (int i = 0; i < 4; i++) exp_pay(words[i]);
      expq.push_back(ecrc);
      exp_trail(ecrc);
      run_pkt("long8", 2'd0, 6'h2A, 16'd8, 0, 1);
      compare("long8");
      chk("long8.pay_cycles", n_pay, 32'd4);
      chk("long8.underflow", n_unf, 32'd0);

      // same packet, second payload word missing
      expq.delete();
      expq.push_back(16'hB8B8);
      expq.push_back(16'h082A);
      expq.push_back(16'h3500);
      ecrc = 16'hFFFF;
      exp_pay(words[0]);
      exp_pay(16'h0000);
      exp_pay(words[1]);
      exp_pay(words[2]);
      expq.push_back(ecrc);
      exp_trail(ecrc);
      run_pkt("stall", 2'd0, 6'h2A, 16'd8, 2, 1);
      compare("stall");
      chk("stall.pay_cycles", n_pay, 32'd4);
      chk("stall.underflow", n_unf, 32'd1);

      // odd word count rejected, then a normal command
      run_pkt("badwc", 2'd0, 6'h2A, 16'd5, 0, 0);
      chk("badwc.err_wc", n_errwc, 32'd1);
      chk("badwc.hs_cycles", hs_seen, 32'd0);
      chk("badwc.ready", 32'(cmd_ready), 32'd1);
      exp_short_1234();
      run_pkt("after_bad", 2'd1, 6'h01, 16'h1234, 0, 1);
      compare("after_bad");

      // reset in the middle of the payload
      begin
         int seen, c;
         seen = 0; c = 0;
         wait_ready("midrst");
         cmd_vc = 2'd0; cmd_dt = 6'h2A; cmd_wc = 16'd8;
         cmd_valid = 1'b1;
         while (!seen && c < 30) begin
            @(negedge clock);
            c++;
            cmd_valid = 1'b0;
            pay_valid = 1'b1;
            pay_data  = words[0];
            if (pay_ready) seen = 1;
         end
         chk("midrst.in_pay", seen, 32'd1);
         reset = 1'b1;
         @(negedge clock);
         chk("midrst.hs_active", 32'(hs_active), 32'd0);
         chk("midrst.pay_ready", 32'(pay_ready), 32'd0);
         chk("midrst.cmd_ready", 32'(cmd_ready), 32'd0);
         chk("midrst.lanes", 32'(lane_bytes), 32'd0);
         reset = 1'b0;
         pay_valid = 1'b0;
         @(negedge clock);
         chk("midrst.idle", 32'(cmd_ready), 32'd1);
      end
      exp_short_1234();
      run_pkt("post_rst", 2'd1, 6'h01, 16'h1234, 0, 1);
      compare("post_rst");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end
endmodule
